inference_scheduler: RTL and testbench

- Sequences one LeNet inference per received image.
- Waits for the image loader's one-cycle `image_loaded` pulse, then starts each layer engine in order (conv1, pool1, conv2, pool2, fc1, fc2/argmax) using one-hot start/done handshakes.
- Captures the predicted digit and hands one ASCII result byte to the UART transmitter.
- Sits between the image loader, the layer engines and uart_tx. Provides watchdog timeout, overrun detection and latency measurement.

---
 rtl/inference_scheduler.sv | 209 ++++++++++++++++++++
 tb/tb_inference_scheduler.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inference_scheduler.sv
// ============================================================================
// inference_scheduler
//
// Runs one LeNet inference for each image that arrives. After the image
// loader pulses image_loaded, the scheduler starts each layer engine in turn
// (conv1, pool1, conv2, pool2, fc1, fc2/argmax). Each engine gets a one-hot
// start pulse and returns a one-cycle done pulse. The argmax digit from the
// last engine is captured and sent to the UART transmitter as one ASCII byte.
// A per-layer watchdog aborts a stuck layer. Images that arrive while a run
// is in progress are dropped and flagged. The length of each run is measured.
//
// Ports
//   clk             system clock
//   rst             synchronous, active-high reset
//   weights_loaded  level: weight RAMs hold valid data
//   image_loaded    one-cycle pulse: image RAM holds a complete image
//   layer_start     one-hot, one-cycle start pulse to layer engine i
//   layer_done      one-cycle done pulse from layer engine i
//   digit_in        argmax result, valid together with the last done bit
//   tx_busy         UART transmitter busy
//   tx_start        one-cycle send strobe
//   tx_data         byte to send, stable from tx_start to the next tx_start
//   busy            high whenever the scheduler is not idle
//   result_digit    last captured digit
//   result_valid    one-cycle pulse when result_digit updates
//   error           sticky: watchdog timeout or out-of-range digit
//   overrun         sticky: image arrived while busy
//   cycle_count     cycles from leaving IDLE to digit capture, last run
// ============================================================================
module inference_scheduler #(
    parameter int NUM_LAYERS     = 6,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int TMR_W          = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  weights_loaded,
    input  logic                  image_loaded,
    output logic [NUM_LAYERS-1:0] layer_start,
    input  logic [NUM_LAYERS-1:0] layer_done,
    input  logic [3:0]            digit_in,
    input  logic                  tx_busy,
    output logic                  tx_start,
    output logic [7:0]            tx_data,
    output logic                  busy,
    output logic [3:0]            result_digit,
    output logic                  result_valid,
    output logic                  error,
    output logic                  overrun,
    output logic [31:0]           cycle_count
);

    localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LAYERS - 1);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]       ERR_BYTE = 8'h45;   // ASCII 'E'

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_TX,
        S_ABORT
    } state_t;

    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [TMR_W-1:0] timer_q;
    logic [31:0]      cycle_count_q;
    logic [3:0]       result_digit_q;
    logic             result_valid_q;
    logic             error_q;
    logic             overrun_q;
    logic [7:0]       tx_byte_q;     // byte queued for the next send
    logic [7:0]       tx_data_q;     // byte of the most recent send

    logic [31:0]      cycle_count_d;
    logic             done_cur;
    logic             tx_fire;

    // Cycle counter that sticks at all-ones and never wraps.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // ASCII digit for 0..9. Any other value becomes 'E'.
    function automatic logic [7:0] digit_byte(input logic [3:0] d);
        return (d > 4'd9) ? ERR_BYTE : 8'h30 + {4'h0, d};
    endfunction

    assign cycle_count_d = sat_inc32(cycle_count_q);

    // Only the engine currently being waited on can finish the layer.
    // Done bits from any other engine are ignored.
    assign done_cur = layer_done[idx_q];

    // The byte goes out in the first TX cycle in which the transmitter is
    // free. If the weights are lost in that same cycle, the abort wins.
    assign tx_fire = (state_q == S_TX) && !tx_busy && weights_loaded;

    // These strobes are gated with rst so that no pulse leaves the block
    // during the reset cycle, whatever state the FSM was in.
    assign tx_start = tx_fire && !rst;

    always_comb begin
        layer_start = '0;
        if (state_q == S_START && weights_loaded && !rst) begin
            layer_start[idx_q] = 1'b1;
        end
    end

    // tx_data shows the new byte in the strobe cycle itself, then holds it.
    assign tx_data      = tx_start ? tx_byte_q : tx_data_q;
    assign busy         = (state_q != S_IDLE);
    assign result_digit = result_digit_q;
    assign result_valid = result_valid_q;
    assign error        = error_q;
    assign overrun      = overrun_q;
    assign cycle_count  = cycle_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            idx_q          <= '0;
            timer_q        <= '0;
            cycle_count_q  <= '0;
            result_digit_q <= '0;
            result_valid_q <= 1'b0;
            error_q        <= 1'b0;
            overrun_q      <= 1'b0;
            tx_byte_q      <= '0;
            tx_data_q      <= '0;
        end else begin
            result_valid_q <= 1'b0;

            // A new image during a run is dropped. The run carries on.
            if (image_loaded && state_q != S_IDLE) begin
                overrun_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (image_loaded && weights_loaded) begin
                        idx_q         <= '0;
                        cycle_count_q <= '0;
                        state_q       <= S_START;
                    end
                end

                S_START: begin
                    if (!weights_loaded) begin
                        state_q <= S_ABORT;
                    end else begin
                        timer_q       <= '0;
                        cycle_count_q <= cycle_count_d;
                        state_q       <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (!weights_loaded) begin
                        state_q <= S_ABORT;
                    end else begin
                        timer_q       <= timer_q + TMR_W'(1);
                        cycle_count_q <= cycle_count_d;
                        // A done that lands on the last watchdog cycle
                        // still counts as a completion.
                        if (done_cur) begin
                            if (idx_q == LAST_IDX) begin
                                result_digit_q <= digit_in;
                                result_valid_q <= 1'b1;
                                tx_byte_q      <= digit_byte(digit_in);
                                if (digit_in > 4'd9) begin
                                    error_q <= 1'b1;
                                end
                                state_q <= S_TX;
                            end else begin
                                idx_q   <= idx_q + IDX_W'(1);
                                state_q <= S_START;
                            end
                        end else if (timer_q == TMO_LAST) begin
                            error_q   <= 1'b1;
                            tx_byte_q <= ERR_BYTE;
                            state_q   <= S_TX;
                        end
                    end
                end

                S_TX: begin
                    if (!weights_loaded) begin
                        state_q <= S_ABORT;
                    end else if (tx_fire) begin
                        tx_data_q <= tx_byte_q;
                        state_q   <= S_IDLE;
                    end
                end

                S_ABORT: begin
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inference_scheduler.sv
module tb_inference_scheduler;

    localparam int NL  = 6;
    localparam int TMO = 100;

    typedef int lat_t [NL];

    logic          clk = 1'b0;
    logic          rst;
    logic          weights_loaded;
    logic          image_loaded;
    logic [NL-1:0] layer_start;
    logic [NL-1:0] layer_done;
    logic [3:0]    digit_in;
    logic          tx_busy;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          busy;
    logic [3:0]    result_digit;
    logic          result_valid;
    logic          error;
    logic          overrun;
    logic [31:0]   cycle_count;

    inference_scheduler #(
        .NUM_LAYERS    (NL),
        .TIMEOUT_CYCLES(TMO),
        .TMR_W         (24)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .weights_loaded(weights_loaded),
        .image_loaded  (image_loaded),
        .layer_start   (layer_start),
        .layer_done    (layer_done),
        .digit_in      (digit_in),
        .tx_busy       (tx_busy),
        .tx_start      (tx_start),
        .tx_data       (tx_data),
        .busy          (busy),
        .result_digit  (result_digit),
        .result_valid  (result_valid),
        .error         (error),
        .overrun       (overrun),
        .cycle_count   (cycle_count)
    );

    initial forever #5 clk = ~clk;

    // Cycle index as seen at the falling edge of each clock period.
    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    int checks = 0;
    int passes = 0;

    typedef struct { int idx; int cy; }             st_e;
    typedef struct { int dig; longint cc; int cy; } res_e;
    typedef struct { int b; int cy; }               tx_e;

    st_e  q_st [$];
    res_e q_res[$];
    tx_e  q_tx [$];

    bit err_m = 1'b0;
    bit ovr_m = 1'b0;

    function automatic void chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    initial begin
        st_e  s;
        res_e r;
        tx_e  t;
        forever begin
            @(negedge clk);
            if (layer_start != '0) begin
                chk("start onehot", longint'($onehot(layer_start)), 1);
                if (q_st.size() == 0) begin
                    chk("unexpected layer_start", longint'(layer_start), 0);
                end else begin
                    s = q_st.pop_front();
                    chk("start index", longint'(layer_start), longint'(1) << s.idx);
                    chk("start cycle", cyc, s.cy);
                end
            end
            if (result_valid) begin
                if (q_res.size() == 0) begin
                    chk("unexpected result_valid", 1, 0);
                end else begin
                    r = q_res.pop_front();
                    chk("result_digit", result_digit, r.dig);
                    chk("cycle_count", cycle_count, r.cc);
                    chk("result cycle", cyc, r.cy);
                end
            end
            if (tx_start) begin
                if (q_tx.size() == 0) begin
                    chk("unexpected tx_start", 1, 0);
                end else begin
                    t = q_tx.pop_front();
                    chk("tx_data", tx_data, t.b);
                    chk("tx cycle", cyc, t.cy);
                end
            end
        end
    end

    // One inference. The expected event timeline is computed from the
    // latencies first. The loop then acts as the layer engines and the
    // UART and reacts to the DUT's start pulses.
    task automatic run(input int digit, input lat_t lat, input int hang, input int abrt,
                       input int rstl, input bit ovr, input bit spur, input int bsy);
        int     t0, s, e_cy, tmo_c, ab_c, rs_c, ovr_c, spur_c;
        longint cc;
        bit     done_ok, finished;
        int     done_at [NL];

        @(posedge clk); #1;
        t0             = cyc;
        image_loaded   = 1'b1;
        weights_loaded = 1'b1;
        digit_in       = 4'(digit);
        tx_busy        = 1'b0;
        layer_done     = '0;

        s = t0 + 1; cc = 0; done_ok = 0; e_cy = -1;
        tmo_c = -1; ab_c = -1; rs_c = -1; ovr_c = -1; spur_c = -1;
        for (int i = 0; i < NL; i++) begin
            q_st.push_back('{i, s});
            if (i == 1) begin
                ovr_c  = ovr  ? s + 2 : -1;
                spur_c = spur ? s + 1 : -1;
            end
            if (i == hang) begin tmo_c = s + TMO; e_cy = tmo_c; break; end
            if (i == abrt) begin ab_c = s + 4; break; end
            if (i == rstl) begin rs_c = s + 3; break; end
            cc += lat[i] + 1;
            if (i == NL - 1) begin e_cy = s + lat[i]; done_ok = 1; end
            s += lat[i] + 1;
        end
        if (done_ok) q_res.push_back('{digit, cc, e_cy + 1});
        if (e_cy >= 0)
            q_tx.push_back('{(done_ok && digit <= 9) ? 8'h30 + digit : 8'h45,
                             (bsy > 1) ? e_cy + bsy : e_cy + 1});
        if (rstl >= 0) begin
            err_m = 0;
            ovr_m = 0;
        end else begin
            if (tmo_c >= 0 || (done_ok && digit > 9)) err_m = 1;
            if (ovr) ovr_m = 1;
        end

        foreach (done_at[i]) done_at[i] = -1;
        finished = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            for (int i = 0; i < NL; i++)
                if (layer_start[i] && i != hang) done_at[i] = cyc + lat[i];
            if (k > 0 && !busy) begin finished = 1; break; end
            @(posedge clk); #1;
            image_loaded = (cyc == ovr_c);
            rst          = (cyc == rs_c);
            if (ab_c >= 0 && cyc >= ab_c) weights_loaded = 1'b0;
            tx_busy = (e_cy >= 0 && cyc >= e_cy && cyc < e_cy + bsy);
            for (int i = 0; i < NL; i++)
                layer_done[i] = (cyc == done_at[i]) || (i == 4 && cyc == spur_c);
        end
        chk("run returned to idle", finished, 1);

        if (rstl >= 0) begin
            chk("post-rst layer_start", longint'(layer_start), 0);
            chk("post-rst tx_start/valid/tx_data",
                longint'({tx_start, result_valid, tx_data}), 0);
            chk("post-rst result_digit", result_digit, 0);
            chk("post-rst cycle_count", cycle_count, 0);
        end

        @(posedge clk); #1;
        image_loaded   = 1'b0;
        layer_done     = '0;
        rst            = 1'b0;
        weights_loaded = 1'b1;
        tx_busy        = 1'b0;
        repeat (2) @(negedge clk);
        chk("error flag", error, err_m);
        chk("overrun flag", overrun, ovr_m);
        chk("busy after run", busy, 0);
        chk("pending starts", q_st.size(), 0);
        chk("pending results", q_res.size(), 0);
        chk("pending tx", q_tx.size(), 0);
    endtask

    initial begin
        lat_t L;
        rst            = 1'b1;
        weights_loaded = 1'b1;
        image_loaded   = 1'b0;
        layer_done     = '0;
        digit_in       = '0;
        tx_busy        = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset error", error, 0);
        chk("reset overrun", overrun, 0);
        chk("reset result", longint'({result_valid, result_digit}), 0);
        chk("reset cycle_count", cycle_count, 0);
        chk("reset tx", longint'({tx_start, tx_data, layer_start}), 0);

        // An image that arrives without weights is ignored and sets no flag.
        @(posedge clk); #1;
        weights_loaded = 1'b0;
        image_loaded   = 1'b1;
        @(posedge clk); #1;
        image_loaded = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("no-weights stays idle", busy, 0);
        end
        chk("no-weights overrun", overrun, 0);
        weights_loaded = 1'b1;

        // Nominal: 10-cycle layers, digit 7.
        L = '{10, 10, 10, 10, 10, 10};
        run(7, L, -1, -1, -1, 0, 0, 0);

        // Randomised latencies, digits and transmitter busy time.
        for (int r = 0; r < 6; r++) begin
            foreach (L[i]) L[i] = int'($urandom_range(1, 20));
            run(int'($urandom_range(0, 9)), L, -1, -1, -1, 0, 0, int'($urandom_range(0, 4)));
        end

        // Done on the last watchdog cycle beats the timeout.
        L = '{TMO, 2, 1, 3, 2, 1};
        run(0, L, -1, -1, -1, 0, 0, 0);
        chk("done-at-limit no error", error, 0);

        // Layer 2 never finishes.
        L = '{5, 6, 7, 8, 9, 10};
        run(5, L, 2, -1, -1, 0, 0, 0);

        // Second image and a stray done bit during layer 1.
        L = '{4, 10, 6, 5, 7, 3};
        run(9, L, -1, -1, -1, 1, 1, 0);

        // Transmitter backpressure.
        L = '{3, 4, 5, 6, 7, 8};
        run(3, L, -1, -1, -1, 0, 0, 50);

        // Weights lost during layer 3.
        L = '{3, 3, 3, 10, 3, 3};
        run(1, L, -1, 3, -1, 0, 0, 0);

        // Reset in the middle of layer 1, then a normal run.
        L = '{4, 10, 4, 4, 4, 4};
        run(2, L, -1, -1, 1, 0, 0, 0);
        L = '{10, 10, 10, 10, 10, 10};
        run(8, L, -1, -1, -1, 0, 0, 0);

        // Out-of-range digit.
        L = '{2, 3, 2, 3, 2, 3};
        run(12, L, -1, -1, -1, 0, 0, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
